// File: rtl/branch_predict_unit.sv
// Decode-stage branch resolution plus a fetch-stage table of 2-bit saturating counters.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned INDEX_LSB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      PCF,
  output logic             PredTakenF,
  input  logic [31:0]      PCD,
  input  logic             PredTakenD,
  input  logic             BranchD,
  input  logic             BeqD,
  input  logic             BneD,
  input  logic             JumpTypeD,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  input  logic             StallD,
  output logic [2:0]       PCSrcD,
  output logic             MispredictD
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]      BranchCount,
  output logic [31:0]      MispredCount
`endif
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  localparam logic [2:0] PcSeq    = 3'b000;
  localparam logic [2:0] PcBranch = 3'b001;
  localparam logic [2:0] PcJump   = 3'b010;
  localparam logic [2:0] PcReg    = 3'b011;
  localparam logic [2:0] PcRecov  = 3'b100;

  logic [1:0]      cnt_q [ENTRIES];
  logic [1:0]      cnt_d;
  logic [IdxW-1:0] idx_f;
  logic [IdxW-1:0] idx_d;
  logic            is_jr;
  logic            is_j;
  logic            is_cond;
  logic            taken;
  logic            train_en;
  logic            unused_pc;

  assign idx_f     = PCF[INDEX_LSB +: IdxW];
  assign idx_d     = PCD[INDEX_LSB +: IdxW];
  assign unused_pc = ^{PCF, PCD};

  // No bypass: a same-cycle write to idx_f is only seen after the edge.
  assign PredTakenF = cnt_q[idx_f][1];

  always_comb begin
    is_jr       = BranchD & ~BeqD & ~BneD & JumpTypeD;
    is_j        = BranchD & ~BeqD & ~BneD & ~JumpTypeD;
    is_cond     = BranchD & (BeqD ^ BneD);
    taken       = BeqD ? (Src1 == Src2) : (Src1 != Src2);
    train_en    = is_cond & ~StallD;
    PCSrcD      = PcSeq;
    MispredictD = 1'b0;
    if (is_jr) begin
      PCSrcD = PcReg;
    end else if (is_j) begin
      PCSrcD = PcJump;
    end else if (is_cond && (taken != PredTakenD)) begin
      PCSrcD      = taken ? PcBranch : PcRecov;
      MispredictD = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q[idx_d];
    if (taken && (cnt_d != 2'b11)) begin
      cnt_d = cnt_d + 2'b01;
    end else if (!taken && (cnt_d != 2'b00)) begin
      cnt_d = cnt_d - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else if (train_en) begin
      cnt_q[idx_d] <= cnt_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (train_en && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (train_en && MispredictD && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios then randomized traffic
// against a behavioural counter-table model.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF, PCD, Src1, Src2;
  logic        PredTakenF, PredTakenD;
  logic        BranchD, BeqD, BneD, JumpTypeD, StallD;
  logic [2:0]  PCSrcD;
  logic        MispredictD;
`ifdef BPU_STATS_EN
  logic [31:0] BranchCount, MispredCount;
`endif

  int checks;
  int failures;
  int mdl [64];
  int m_branches;
  int m_mispreds;

  branch_predict_unit #(.WIDTH(32), .ENTRIES(64), .INDEX_LSB(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCF        (PCF),
    .PredTakenF (PredTakenF),
    .PCD        (PCD),
    .PredTakenD (PredTakenD),
    .BranchD    (BranchD),
    .BeqD       (BeqD),
    .BneD       (BneD),
    .JumpTypeD  (JumpTypeD),
    .Src1       (Src1),
    .Src2       (Src2),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .MispredictD(MispredictD)
`ifdef BPU_STATS_EN
    ,
    .BranchCount (BranchCount),
    .MispredCount(MispredCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit is_cond();
    return BranchD && (BeqD != BneD);
  endfunction

  function automatic bit outcome();
    if (BeqD) return Src1 == Src2;
    return Src1 != Src2;
  endfunction

  // Expected next-PC select from the decode rules.
  function automatic logic [2:0] exp_pcsrc();
    if (!BranchD || (BeqD && BneD)) return 3'b000;
    if (!BeqD && !BneD) return JumpTypeD ? 3'b011 : 3'b010;
    if (outcome() == PredTakenD) return 3'b000;
    return outcome() ? 3'b001 : 3'b100;
  endfunction

  function automatic logic exp_mis();
    return is_cond() && (outcome() != PredTakenD);
  endfunction

  function automatic logic exp_pred(input logic [31:0] pc);
    return mdl[idx(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 1;
    m_branches = 0;
    m_mispreds = 0;
  endtask

  task automatic drive(input logic [31:0] pcf, input logic [31:0] pcd, input logic pred,
                       input logic br, input logic beq, input logic bne, input logic jt,
                       input logic [31:0] s1, input logic [31:0] s2, input logic stall);
    PCF = pcf; PCD = pcd; PredTakenD = pred; BranchD = br; BeqD = beq; BneD = bne;
    JumpTypeD = jt; Src1 = s1; Src2 = s2; StallD = stall;
    #1;
  endtask

  // One rising edge; the model trains from the inputs presented before it.
  task automatic clock_edge();
    bit tr, tk, mis;
    int i;
    tr  = is_cond() && !StallD && rst_n;
    tk  = outcome();
    mis = exp_mis();
    i   = idx(PCD);
    @(posedge clk);
    if (tr) begin
      if (tk) mdl[i] = (mdl[i] == 3) ? 3 : mdl[i] + 1;
      else    mdl[i] = (mdl[i] == 0) ? 0 : mdl[i] - 1;
      m_branches++;
      if (mis) m_mispreds++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #10;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] pcs [3];
      pcs = '{32'h0, 32'h4, 32'hFC};
      PCF = pcs[k];
      #1;
      checks++;
      if (PredTakenF !== 1'b0) begin
        failures++;
        $display("FAIL reset_pred pc=%h got=%b exp=0", PCF, PredTakenF);
      end
    end
    checks++;
    if (PCSrcD !== 3'b000 || MispredictD !== 1'b0) begin
      failures++;
      $display("FAIL reset_pcsrc got=%b/%b exp=000/0", PCSrcD, MispredictD);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_train_beq();
    drive(32'h0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0);
    checks++;
    if (PCSrcD !== 3'b001 || MispredictD !== 1'b1) begin
      failures++;
      $display("FAIL beq_mispredict got=%b/%b exp=001/1", PCSrcD, MispredictD);
    end
    clock_edge();
    PCF = 32'h40;
    #1;
    checks++;
    if (PredTakenF !== 1'b1) begin
      failures++;
      $display("FAIL beq_trained_pred got=%b exp=1", PredTakenF);
    end
    PredTakenD = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (PCSrcD !== 3'b000 || MispredictD !== 1'b0) begin
        failures++;
        $display("FAIL beq_correct got=%b/%b exp=000/0", PCSrcD, MispredictD);
      end
      clock_edge();
    end
  endtask

  task automatic test_bne_mispredict();
    // Counter should sit at 11 now; one decrement still predicts taken.
    drive(32'h40, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 32'd7, 1'b0);
    checks++;
    if (PCSrcD !== 3'b100 || MispredictD !== 1'b1) begin
      failures++;
      $display("FAIL bne_recover got=%b/%b exp=100/1", PCSrcD, MispredictD);
    end
    clock_edge();
    checks++;
    if (PredTakenF !== 1'b1 || mdl[16] != 2) begin
      failures++;
      $display("FAIL bne_saturated got=%b exp=1 (model=%0d)", PredTakenF, mdl[16]);
    end
  endtask

  task automatic test_stall();
    drive(32'h40, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (PCSrcD !== 3'b100 || MispredictD !== 1'b1) begin
        failures++;
        $display("FAIL stall_redirect cyc=%0d got=%b/%b exp=100/1", k, PCSrcD, MispredictD);
      end
      clock_edge();
    end
    BranchD = 1'b0;
    StallD  = 1'b0;
    #1;
    checks++;
    if (PredTakenF !== exp_pred(32'h40) || PredTakenF !== 1'b1) begin
      failures++;
      $display("FAIL stall_no_train got=%b exp=1", PredTakenF);
    end
  endtask

  task automatic test_jumps();
    logic [2:0] exp_sel [3];
    logic       beqs    [3];
    logic       jts     [3];
    exp_sel = '{3'b011, 3'b010, 3'b000};
    beqs    = '{1'b0, 1'b0, 1'b1};
    jts     = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      // Operands unequal: a wrongly trained entry would move toward not-taken.
      drive(32'h40, 32'h40, 1'b1, 1'b1, beqs[k], beqs[k], jts[k], 32'd1, 32'd2, 1'b0);
      checks++;
      if (PCSrcD !== exp_sel[k] || MispredictD !== 1'b0) begin
        failures++;
        $display("FAIL jump_decode k=%0d got=%b/%b exp=%b/0", k, PCSrcD, MispredictD,
                 exp_sel[k]);
      end
      clock_edge();
      clock_edge();
    end
    checks++;
    if (PredTakenF !== 1'b1) begin
      failures++;
      $display("FAIL jump_no_train got=%b exp=1", PredTakenF);
    end
`ifdef BPU_STATS_EN
    checks++;
    if (BranchCount !== 32'd4 || MispredCount !== 32'd2) begin
      failures++;
      $display("FAIL stats_seq got=%0d/%0d exp=4/2", BranchCount, MispredCount);
    end
`endif
  endtask

  task automatic test_alias();
    // Entry 16 is weak-taken; a not-taken beq at 0x140 trains it to weak-NT.
    drive(32'h40, 32'h140, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd9, 1'b0);
    checks++;
    if (PredTakenF !== 1'b1) begin
      failures++;
      $display("FAIL alias_old got=%b exp=1", PredTakenF);
    end
    clock_edge();
    checks++;
    if (PredTakenF !== 1'b0) begin
      failures++;
      $display("FAIL alias_new got=%b exp=0", PredTakenF);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] s1, s2;
      logic        br;
      s1 = $urandom;
      s2 = ($urandom_range(0, 1) == 1) ? s1 : $urandom;
      br = ($urandom_range(0, 7) != 0);
      drive({24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'b00},
            {22'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'b00},
            1'($urandom), br, 1'($urandom), 1'($urandom), 1'($urandom), s1, s2,
            ($urandom_range(0, 3) == 0));
      checks++;
      if (PCSrcD !== exp_pcsrc() || MispredictD !== exp_mis()
          || PredTakenF !== exp_pred(PCF)) begin
        failures++;
        $display("FAIL random n=%0d pcsrc=%b/%b mis=%b/%b pred=%b/%b", n, PCSrcD,
                 exp_pcsrc(), MispredictD, exp_mis(), PredTakenF, exp_pred(PCF));
      end
      clock_edge();
    end
`ifdef BPU_STATS_EN
    checks++;
    if (BranchCount !== 32'(m_branches) || MispredCount !== 32'(m_mispreds)) begin
      failures++;
      $display("FAIL stats_random got=%0d/%0d exp=%0d/%0d", BranchCount, MispredCount,
               m_branches, m_mispreds);
    end
`endif
  endtask

  task automatic test_async_reset();
    // Make entry 16 predict taken, then pull reset between edges.
    drive(32'h40, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 1'b0);
    clock_edge();
    clock_edge();
    checks++;
    if (PredTakenF !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got=%b exp=1", PredTakenF);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (PredTakenF !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_pred got=%b exp=0", PredTakenF);
    end
`ifdef BPU_STATS_EN
    checks++;
    if (BranchCount !== 32'd0 || MispredCount !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_stats got=%0d/%0d exp=0/0", BranchCount, MispredCount);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    clock_edge();
    checks++;
    if (PredTakenF !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_train got=%b exp=1", PredTakenF);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_train_beq();
    test_bne_mispredict();
    test_stall();
    test_jumps();
    test_alias();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
